if_id_pipe_reg: RTL

Parametrised IF/ID pipeline stage register that replaces the plain fetch/decode latch. It carries the instruction and PC+4 from fetch to decode using a valid/ready handshake. A two-entry skid buffer keeps the upstream ready signal registered. The block also supports a flush that squashes to a NOP, and saturating stall/flush event counters for performance debug.

---
 rtl/if_id_pipe_reg.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a two-entry skid buffer.
// The upstream ready is a flop, and saturating stall/flush counters are kept for debug.
module if_id_pipe_reg #(
    parameter int unsigned        INSTR_W   = 32,
    parameter int unsigned        PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int unsigned        CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inValid,
    output logic               inReady,
    input  logic [INSTR_W-1:0] instructionIn,
    input  logic [PC_W-1:0]    PCplus4In,
    input  logic               IF_Flush,
    output logic               outValid,
    input  logic               outReady,
    output logic [INSTR_W-1:0] instructionOut,
    output logic [PC_W-1:0]    PCplus4Out,
    output logic [CNT_W-1:0]   stallCount,
    output logic [CNT_W-1:0]   flushCount
);

    typedef enum logic [1:0] {StEmpty, StMain, StFull} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = 1;

    state_e             st_q, st_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic accept;
    logic deliver;
    logic stall_evt;

    assign accept    = inValid & in_ready_q;
    assign deliver   = out_valid_q & outReady;
    assign stall_evt = out_valid_q & ~outReady;

    always_comb begin
        st_d         = st_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (IF_Flush) begin
            // Squash everything held and anything accepted this cycle.
            st_d         = StEmpty;
            in_ready_d   = 1'b1;
            out_valid_d  = 1'b0;
            main_instr_d = NOP_INSTR;
            main_pc_d    = PCplus4In;
        end else begin
            unique case (st_q)
                StEmpty: begin
                    if (accept) begin
                        st_d         = StMain;
                        out_valid_d  = 1'b1;
                        main_instr_d = instructionIn;
                        main_pc_d    = PCplus4In;
                    end
                end
                StMain: begin
                    if (accept && deliver) begin
                        main_instr_d = instructionIn;
                        main_pc_d    = PCplus4In;
                    end else if (accept) begin
                        // Decode stalled: park the new instruction and drop ready.
                        st_d         = StFull;
                        in_ready_d   = 1'b0;
                        skid_instr_d = instructionIn;
                        skid_pc_d    = PCplus4In;
                    end else if (deliver) begin
                        st_d         = StEmpty;
                        out_valid_d  = 1'b0;
                        main_instr_d = NOP_INSTR;
                    end
                end
                StFull: begin
                    if (deliver) begin
                        st_d         = StMain;
                        in_ready_d   = 1'b1;
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                    end
                end
                default: begin
                    st_d         = StEmpty;
                    in_ready_d   = 1'b1;
                    out_valid_d  = 1'b0;
                    main_instr_d = NOP_INSTR;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
        if (IF_Flush && (flush_cnt_q != CntMax)) begin
            flush_cnt_d = flush_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q         <= StEmpty;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            main_instr_q <= NOP_INSTR;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            st_q         <= st_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign inReady        = in_ready_q;
    assign outValid       = out_valid_q;
    assign instructionOut = main_instr_q;
    assign PCplus4Out     = main_pc_q;
    assign stallCount     = stall_cnt_q;
    assign flushCount     = flush_cnt_q;

endmodule
